// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the cdc_fifo write-side arbiter.
// Holds the arbiter state encoding, the statistics counter width and the
// round-robin search used to pick the next owner of the FIFO write port.
package cdc_fifo_pkg;

  // Arbiter FSM states: IDLE arbitrates, GRANT streams words from one owner.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Width of every statistics counter (saturating at all-ones).
  localparam int STATS_WIDTH = 8;

  // Widest requester vector the round-robin helper supports.
  localparam int MAX_REQUESTERS = 8;
  localparam int MAX_INDEX_W    = 3;

  // Round-robin search: first set bit of valid_vector at or above pointer,
  // wrapping to the lowest set bit when nothing at or above pointer is set.
  // Callers zero-extend narrower vectors; unused upper bits must be zero.
  function automatic logic [MAX_INDEX_W-1:0] next_index(
    input logic [MAX_INDEX_W-1:0]    pointer,
    input logic [MAX_REQUESTERS-1:0] valid_vector
  );
    logic [MAX_REQUESTERS-1:0] upper_mask;
    logic [MAX_REQUESTERS-1:0] masked;
    logic [MAX_INDEX_W-1:0]    idx;
    upper_mask = ~((MAX_REQUESTERS'(1) << pointer) - MAX_REQUESTERS'(1));
    masked     = valid_vector & upper_mask;
    idx        = '0;
    // Scan downward so the lowest qualifying index wins last.
    for (int i = MAX_REQUESTERS - 1; i >= 0; i--) begin
      if (masked == '0) begin
        if (valid_vector[i]) idx = MAX_INDEX_W'(i);
      end else if (masked[i]) begin
        idx = MAX_INDEX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational masked round-robin picker.
// Produces a one-hot selection of the first valid requester at or after
// pointer (wrapping), plus a flag telling whether any requester is valid.
module rr_priority_picker
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int IDX_W          = $clog2(NUM_REQUESTERS)
) (
  input  logic [IDX_W-1:0]          pointer,
  input  logic [NUM_REQUESTERS-1:0] valid,
  output logic [NUM_REQUESTERS-1:0] one_hot,
  output logic                      any_valid
);

  logic [MAX_INDEX_W-1:0] pick_idx;

  // Search from the pointer and expand the winning index to one-hot.
  always_comb begin
    any_valid = |valid;
    pick_idx  = next_index(MAX_INDEX_W'(pointer), MAX_REQUESTERS'(valid));
    one_hot   = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      one_hot[i] = any_valid && (pick_idx == MAX_INDEX_W'(i));
    end
  end

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing the single write port of cdc_fifo between
// NUM_REQUESTERS producers in the FIFO write clock domain.
// An owner keeps the grant for at most MAX_BURST accepted words, or until
// it drops valid; one idle arbitration cycle always separates grants.
// Handshake: requester i transfers a word on a rising edge where
// request_valid[i] && request_ready[i]; ready is only ever offered to the
// current owner while the FIFO is not full, and the owner's data must stay
// stable while valid is high and ready is low.
// Optional build macro CDC_FIFO_WRITE_ARBITER_STATS_EN adds per-requester
// accepted-word counters and a full-stall counter.
// The FSM state is visible on busy (high exactly in ARB_GRANT).
module cdc_fifo_write_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 4,
  parameter int MAX_BURST      = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQUESTERS-1:0]          request_valid,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data,
  output logic [NUM_REQUESTERS-1:0]          request_ready,
  input  logic                               full,
  output logic [DATA_WIDTH-1:0]              write_data,
  output logic                               write_increment,
  output logic [NUM_REQUESTERS-1:0]          grant,
  output logic                               busy
`ifdef CDC_FIFO_WRITE_ARBITER_STATS_EN
  ,
  input  logic [$clog2(NUM_REQUESTERS)-1:0]  stats_select,
  output logic [STATS_WIDTH-1:0]             stats_count,
  output logic [STATS_WIDTH-1:0]             stall_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  arb_state_t          state;
  logic [IDX_W-1:0]    pointer;
  logic [BC_W-1:0]     burst_count;

  logic [NUM_REQUESTERS-1:0] pick_one_hot;
  logic                      any_valid;
  logic [IDX_W-1:0]          owner_idx;
  logic [IDX_W-1:0]          next_pointer;
  logic                      owner_valid;
  logic                      accept;
  logic                      last_word;
  logic                      release_grant;

  rr_priority_picker #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .IDX_W          (IDX_W)
  ) u_picker (
    .pointer   (pointer),
    .valid     (request_valid),
    .one_hot   (pick_one_hot),
    .any_valid (any_valid)
  );

  // Steer the owner's word to the FIFO and gate the handshake on full/reset.
  always_comb begin
    owner_idx  = '0;
    write_data = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant[i]) begin
        owner_idx  = IDX_W'(i);
        write_data = request_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    owner_valid     = |(request_valid & grant);
    // Reset suppresses the handshake so an aborted burst never writes.
    accept          = (state == ARB_GRANT) && owner_valid && !full && !reset;
    request_ready   = ((state == ARB_GRANT) && !full && !reset) ? grant : '0;
    write_increment = accept;
    busy            = (state == ARB_GRANT);
    last_word       = (burst_count == BC_W'(MAX_BURST - 1));
    release_grant   = !owner_valid || (accept && last_word);
    next_pointer    = (owner_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0
                                                                : owner_idx + IDX_W'(1);
  end

  // Arbiter FSM: arbitrate in IDLE, count burst words and release in GRANT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      pointer     <= '0;
      burst_count <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            grant       <= pick_one_hot;
            burst_count <= '0;
            state       <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (release_grant) begin
            pointer     <= next_pointer;
            grant       <= '0;
            burst_count <= '0;
            state       <= ARB_IDLE;
          end else if (accept) begin
            burst_count <= burst_count + BC_W'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef CDC_FIFO_WRITE_ARBITER_STATS_EN
  logic [STATS_WIDTH-1:0] word_counters [NUM_REQUESTERS];
  logic [STATS_WIDTH-1:0] stall_q;

  // Saturating per-requester accepted-word counters and full-stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQUESTERS; i++) word_counters[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (accept && grant[i] && (word_counters[i] != '1)) begin
          word_counters[i] <= word_counters[i] + STATS_WIDTH'(1);
        end
      end
      if ((state == ARB_GRANT) && full && (stall_q != '1)) begin
        stall_q <= stall_q + STATS_WIDTH'(1);
      end
    end
  end

  // Read-out mux; selections beyond NUM_REQUESTERS read as zero.
  always_comb begin
    stats_count = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (stats_select == IDX_W'(i)) stats_count = word_counters[i];
    end
    stall_count = stall_q;
  end
`endif

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Bench for cdc_fifo_write_arbiter (NUM_REQUESTERS=4, DATA_WIDTH=4,
// MAX_BURST=4). Each requester sends words {id[1:0], seq[1:0]}; expected
// {grant, write_data} pairs are queued as stimulus is issued and a
// monitor pops one per write_increment.
module tb_cdc_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int W  = N + DW;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    request_valid;
  logic [N*DW-1:0] request_data;
  logic [N-1:0]    request_ready;
  logic            full;
  logic [DW-1:0]   write_data;
  logic            write_increment;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef CDC_FIFO_WRITE_ARBITER_STATS_EN
  logic [1:0]      stats_select;
  logic [7:0]      stats_count;
  logic [7:0]      stall_count;
`endif

  cdc_fifo_write_arbiter #(
    .NUM_REQUESTERS (N),
    .DATA_WIDTH     (DW),
    .MAX_BURST      (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .request_valid   (request_valid),
    .request_data    (request_data),
    .request_ready   (request_ready),
    .full            (full),
    .write_data      (write_data),
    .write_increment (write_increment),
    .grant           (grant),
    .busy            (busy)
`ifdef CDC_FIFO_WRITE_ARBITER_STATS_EN
    ,
    .stats_select    (stats_select),
    .stats_count     (stats_count),
    .stall_count     (stall_count)
`endif
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         assertions = 0;
  int         failures   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int         rem[N];
  int         sent[N];
  int         write_count = 0;
  logic       checks_on = 1'b0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Driver tasks
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      request_valid[i]           = (rem[i] > 0);
      request_data[i*DW +: DW]   = {2'(i), 2'(sent[i])};
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
    end
    drive();
  endtask

  // One clock: sample handshakes at the edge, advance producers after it.
  task automatic tick();
    logic [N-1:0] fired;
    @(posedge clock);
    fired = request_valid & request_ready;
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) begin
        sent[i]++;
        rem[i]--;
      end
    end
    drive();
  endtask

  task automatic push_words(input int req, input int first, input int count);
    for (int k = 0; k < count; k++) begin
      exp_q.push_back({4'(1 << req), 2'(req), 2'(first + k)});
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((pending() != 0 || exp_q.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    check(name, exp_q.size() + pending(), 0);
    tick();
    tick();
  endtask

  task automatic wait_sent(input string name, input int req, input int target);
    int c = 0;
    while (sent[req] < target && c < 40) begin
      tick();
      c++;
    end
    check(name, sent[req], target);
  endtask

  // Scoreboard monitor and per-cycle invariants
  always @(negedge clock) begin
    if (checks_on) begin
      check("no_write_when_full", 32'(write_increment & full), 0);
      check("ready_at_most_one", 32'($countones(request_ready) <= 1), 1);
      if (write_increment) begin
        write_count++;
        if (exp_q.size() == 0) begin
          assertions++;
          failures++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", {grant, write_data});
        end else begin
          mon_exp = exp_q.pop_front();
          check("write_word", 32'({grant, write_data}), 32'(mon_exp));
        end
      end
    end
  end

  // Directed tests
  initial begin
    int wc0;
    full = 1'b0;
`ifdef CDC_FIFO_WRITE_ARBITER_STATS_EN
    stats_select = 2'd3;
`endif
    clear_reqs();

    // Reset with every requester valid
    reset = 1'b1;
    rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
    drive();
    push_words(0, 0, 4); push_words(1, 0, 4); push_words(2, 0, 4);
    push_words(3, 0, 4); push_words(0, 4, 4);
    tick();
    checks_on = 1'b1;
    @(negedge clock);
    check("reset_grant", 32'(grant), 0);
    check("reset_write_increment", 32'(write_increment), 0);
    check("reset_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset_grant", 32'(grant), 0);
    tick();
    wc0 = write_count;
    @(negedge clock);
    check("first_grant", 32'(grant), 32'h1);
    check("first_busy", 32'(busy), 1);

    // Rotation: 16 words in 20 cycles
    repeat (20) tick();
    check("sixteen_in_twenty", write_count - wc0, 16);
    drain("rotation_drain", 200);

    // Full stall on req2 after its second word
    clear_reqs();
    rem[2] = 8;
    drive();
    push_words(2, 0, 8);
    wait_sent("stall_setup", 2, 2);
    full = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall_write_increment", 32'(write_increment), 0);
      check("stall_ready", 32'(request_ready[2]), 0);
      check("stall_grant", 32'(grant), 32'h4);
      tick();
    end
    full = 1'b0;
    check("stall_no_transfer", sent[2], 2);
    wait_sent("stall_resume", 2, 4);
    @(negedge clock);
    check("burst_release_grant", 32'(grant), 0);
    tick();
    @(negedge clock);
    check("single_regrant", 32'(grant), 32'h4);
    drain("stall_drain", 200);

    // Early drop by req1, wrap past idle req2 to req3, then req0
    reset = 1'b1;
    clear_reqs();
    tick();
    reset = 1'b0;
    rem[1] = 1; rem[3] = 2;
    drive();
    push_words(1, 0, 1); push_words(3, 0, 2); push_words(0, 0, 2);
    wait_sent("drop_setup", 1, 1);
    rem[0] = 2;
    drive();
    @(negedge clock);
    check("drop_grant_before_release", 32'(grant), 32'h2);
    tick();
    @(negedge clock);
    check("drop_release", 32'(grant), 0);
    tick();
    @(negedge clock);
    check("wrap_to_req3", 32'(grant), 32'h8);
    drain("drop_drain", 200);

    // Reset mid-burst (pointer was 1 before reset)
    clear_reqs();
    rem[2] = 8;
    drive();
    push_words(2, 0, 2);
    wait_sent("midburst_setup", 2, 2);
    reset = 1'b1;
    rem[0] = 2; rem[1] = 2;
    drive();
    @(negedge clock);
    check("no_write_in_reset", 32'(write_increment), 0);
    tick();
    reset = 1'b0;
    push_words(0, 0, 2); push_words(1, 0, 2); push_words(2, 2, 6);
    tick();
    @(negedge clock);
    check("post_reset_grant_req0", 32'(grant), 32'h1);
    drain("midburst_drain", 200);

`ifdef CDC_FIFO_WRITE_ARBITER_STATS_EN
    // Statistics counters
    reset = 1'b1;
    clear_reqs();
    tick();
    reset = 1'b0;
    rem[3] = 10;
    drive();
    push_words(3, 0, 10);
    wait_sent("stats_setup", 3, 1);
    full = 1'b1;
    repeat (3) tick();
    full = 1'b0;
    drain("stats_drain", 200);
    check("stats_count_10", 32'(stats_count), 10);
    check("stall_count_3", 32'(stall_count), 3);
    rem[3] = 300;
    drive();
    push_words(3, 10, 300);
    drain("stats_sat_drain", 1000);
    check("stats_count_sat", 32'(stats_count), 255);
    check("stall_count_hold", 32'(stall_count), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_write_arbiter.md
Name: cdc_fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of cdc_fifo between NUM_REQUESTERS producers in the write clock domain.
- Grants one requester at a time and holds the grant for a bounded burst.
- Gates write_increment against full.
- Sits directly in front of cdc_fifo; its clock is the FIFO write clock and its reset is the FIFO write reset.

Parameters:
NUM_REQUESTERS, 4, number of producers sharing the write port (2..8)
DATA_WIDTH, 4, FIFO word width; must match cdc_fifo DATA_WIDTH
MAX_BURST, 4, maximum accepted words per grant before forced rotation (>=1)

Ports:
clock  input  1  FIFO write clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
request_valid  input  NUM_REQUESTERS  per-requester word valid
request_data  input  NUM_REQUESTERS*DATA_WIDTH  packed words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
request_ready  output  NUM_REQUESTERS  per-requester accept; word i transferred when valid[i]&&ready[i]
full  input  1  cdc_fifo full flag
write_data  output  DATA_WIDTH  to cdc_fifo write_data
write_increment  output  1  to cdc_fifo write_increment
grant  output  NUM_REQUESTERS  registered one-hot current owner; all-zero when idle
busy  output  1  high in GRANT state

Behaviour:
- Reset (sampled at rising edge while reset=1): state=IDLE, grant=0, priority pointer=0, burst_count=0. Combinational outputs follow: request_ready=0, write_increment=0, write_data=0, busy=0. Reset mid-burst aborts the grant; no write occurs in the reset cycle.
- State IDLE:
  - All outputs 0.
  - If any request_valid bit is set, select the first set index searching pointer, pointer+1, ... modulo NUM_REQUESTERS.
  - Register grant=one-hot(index), clear burst_count, go to GRANT.
  - Latency: valid asserted in cycle N gives grant visible in N+1 and earliest write at the end of N+1.
- State GRANT (owner g):
  - write_data = request_data slice g.
  - request_ready[g] = !full; all other ready bits 0.
  - write_increment = request_valid[g] && !full.
  - Each accepted word increments burst_count.
- Release, evaluated each GRANT cycle:
  - (a) request_valid[g]==0, or (b) accepted word with burst_count==MAX_BURST-1.
  - On release: pointer = (g+1) mod NUM_REQUESTERS, grant=0, state=IDLE.
  - One idle arbitration cycle always separates grants.
- full==1: no transfer, burst_count holds, grant holds. No timeout; a stalled owner keeps the grant indefinitely while valid.
- Requester protocol: data is stable while valid && !ready. Dropping valid while granted releases the grant (rule a) with no transfer.
- Single requester: re-granted after one idle cycle; peak throughput MAX_BURST words per MAX_BURST+1 cycles.
- Pointer wraps modulo NUM_REQUESTERS. burst_count is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
- write_increment is never high when full is high. At most one ready bit is high.

Optional Feature:
Macro CDC_FIFO_WRITE_ARBITER_STATS_EN.
- Defined: adds input stats_select (clog2(NUM_REQUESTERS) bits), output stats_count (8), and output stall_count (8).
  - Per-requester 8-bit saturating counters of accepted words.
  - stall_count is a saturating counter of GRANT cycles with full==1.
  - stats_count is combinational: counter[stats_select].
  - All counters clear on reset and saturate at 255.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cdc_fifo_pkg:
  - arbiter state enum (ARB_IDLE, ARB_GRANT)
  - STATS_WIDTH=8 constant
  - function next_index(pointer, valid_vector) for the round-robin search.
- One sub-module: rr_priority_picker (combinational masked round-robin select producing a one-hot result plus an any_valid flag).

Test Plan:
1. Reset check: assert reset for 2 cycles with all valid=1 -> grant=0, write_increment=0, busy=0; after release, grant=0001 one cycle later.
2. Rotation: all 4 requesters hold valid, full=0, MAX_BURST=4 -> 4 writes from req0, 1 idle cycle, then 4 writes from req1, req2, req3, req0 in that order; 16 words in 20 cycles.
3. Full stall: req2 granted, drive full=1 for 5 cycles after its 2nd word -> write_increment=0 and ready[2]=0 throughout; grant held; after full=0, exactly 2 more words, then release.
4. Early drop: req1 granted, drops valid after 1 word -> grant=0 next cycle; next grant goes to req2 if valid, else wraps to req3, then req0.
5. Reset mid-burst: reset asserted after the 2nd word of a burst -> no write in the reset cycle; pointer=0; req0 granted first after release.
6. Stats (macro defined): 10 words from req3 and 3 full cycles during its grant -> stats_select=3 gives stats_count=10, stall_count=3; 300 words saturate the counter at 255.
